// File: rtl/digit_grid_renderer_if.sv
// digit_grid_renderer_if
//   Bundles the beam/digit/cursor inputs and the RGB outputs of the digit grid renderer.
//   master: timing generator / digit source side (drives beam, digits, cursor; reads RGB).
//   slave : renderer side (reads beam, digits, cursor; drives RGB).
//   sx, sy          beam coordinates
//   de              display enable
//   frame_start     one-cycle pulse at frame start
//   numbers_concat  4*ROWS*COLS digit nibbles, MSB nibble = tile 0, row-major
//   numbers_valid   load pulse for numbers_concat
//   cursor_en       cursor enable
//   cursor_idx      row-major tile index to highlight
//   vga_r/g/b       3/3/2-bit colour
interface digit_grid_renderer_if #(
    parameter int unsigned ROWS = 2,
    parameter int unsigned COLS = 6
);
    logic [9:0]              sx;
    logic [9:0]              sy;
    logic                    de;
    logic                    frame_start;
    logic [4*ROWS*COLS-1:0]  numbers_concat;
    logic                    numbers_valid;
    logic                    cursor_en;
    logic [7:0]              cursor_idx;
    logic [2:0]              vga_r;
    logic [2:0]              vga_g;
    logic [1:0]              vga_b;

    modport master (
        output sx, sy, de, frame_start, numbers_concat, numbers_valid, cursor_en, cursor_idx,
        input  vga_r, vga_g, vga_b
    );

    modport slave (
        input  sx, sy, de, frame_start, numbers_concat, numbers_valid, cursor_en, cursor_idx,
        output vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/digit_grid_renderer.sv
// digit_grid_renderer
//   Maps VGA beam coordinates onto a ROWS x COLS grid of seven-segment tiles and renders each
//   pixel through a 3-stage registered pipeline (3 clk latency, one pixel per clock).
//   Digits are double-buffered (shadow -> active on frame_start) so the display never tears;
//   a frame-counted blinking cursor highlights one tile.
//   clk    pixel clock
//   rst_n  asynchronous active-low reset
//   bus    digit_grid_renderer_if.slave (beam, digits, cursor in; RGB out)
module digit_grid_renderer #(
    parameter int unsigned COLS         = 6,
    parameter int unsigned ROWS         = 2,
    parameter int unsigned X0           = 20,
    parameter int unsigned Y0           = 20,
    parameter int unsigned DIGIT_W      = 80,
    parameter int unsigned DIGIT_H      = 140,
    parameter int unsigned X_PITCH      = 100,
    parameter int unsigned Y_PITCH      = 180,
    parameter int unsigned MID_GAP      = 20,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input logic                  clk,
    input logic                  rst_n,
    digit_grid_renderer_if.slave bus
);
    localparam int unsigned NTILES = ROWS * COLS;
    localparam int unsigned NUM_W  = 4 * NTILES;
    localparam int unsigned SEG_T  = DIGIT_W / 8;

    localparam logic [9:0] T_L        = 10'(SEG_T);
    localparam logic [9:0] W_IN       = 10'(DIGIT_W - SEG_T);
    localparam logic [9:0] H_HALF     = 10'(DIGIT_H / 2);
    localparam logic [9:0] G_LO       = 10'(DIGIT_H / 2 - SEG_T / 2);
    localparam logic [9:0] G_HI       = 10'(DIGIT_H / 2 + SEG_T / 2);
    localparam logic [9:0] D_LO       = 10'(DIGIT_H - SEG_T);
    localparam logic [9:0] BLINK_LAST = 10'(BLINK_FRAMES - 1);

    // Bounds are kept in 32-bit arithmetic so edges past 1023 never wrap into view.
    function automatic int unsigned tile_x0(int unsigned c);
        return X0 + c * X_PITCH + ((c >= COLS / 2) ? MID_GAP : 0);
    endfunction

    function automatic int unsigned tile_y0(int unsigned r);
        return Y0 + r * Y_PITCH;
    endfunction

    // Segment set per digit, bit order {g,f,e,d,c,b,a}; 10..15 are blank.
    function automatic logic [6:0] digit_segs(logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Buffered digit / cursor state and blink counter
    logic [NUM_W-1:0] shadow_q;
    logic [NUM_W-1:0] active_q;
    logic             act_cursor_en_q;
    logic [7:0]       act_cursor_idx_q;
    logic [9:0]       frame_cnt_q;
    logic             blink_on_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q         <= '1;
            active_q         <= '1;
            act_cursor_en_q  <= 1'b0;
            act_cursor_idx_q <= 8'd0;
            frame_cnt_q      <= 10'd0;
            blink_on_q       <= 1'b0;
        end else begin
            if (bus.numbers_valid) begin
                shadow_q <= bus.numbers_concat;
            end
            if (bus.frame_start) begin
                // Same-edge load bypasses the shadow so new digits are not a frame late.
                active_q         <= bus.numbers_valid ? bus.numbers_concat : shadow_q;
                act_cursor_en_q  <= bus.cursor_en;
                act_cursor_idx_q <= bus.cursor_idx;
                if (frame_cnt_q == BLINK_LAST) begin
                    frame_cnt_q <= 10'd0;
                    blink_on_q  <= ~blink_on_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 10'd1;
                end
            end
        end
    end

    // S1: tile hit test. Digit and cursor state are looked up here, from the pre-edge active
    // registers, so a commit on an edge only affects pixels sampled after that edge.
    logic       hit_c;
    logic [7:0] idx_c;
    logic [9:0] ox_c;
    logic [9:0] oy_c;
    logic [3:0] digit_c;
    logic       cur_c;

    always_comb begin
        hit_c   = 1'b0;
        idx_c   = 8'd0;
        ox_c    = 10'd0;
        oy_c    = 10'd0;
        digit_c = 4'hF;
        // Descending scan: the last match is the lowest row-major index.
        for (int i = int'(NTILES) - 1; i >= 0; i--) begin
            if (32'(bus.sx) >= tile_x0(unsigned'(i) % COLS) &&
                32'(bus.sx) <  tile_x0(unsigned'(i) % COLS) + DIGIT_W &&
                32'(bus.sy) >= tile_y0(unsigned'(i) / COLS) &&
                32'(bus.sy) <  tile_y0(unsigned'(i) / COLS) + DIGIT_H) begin
                hit_c   = 1'b1;
                idx_c   = 8'(i);
                ox_c    = 10'(32'(bus.sx) - tile_x0(unsigned'(i) % COLS));
                oy_c    = 10'(32'(bus.sy) - tile_y0(unsigned'(i) / COLS));
                digit_c = active_q[4 * (NTILES - 1 - unsigned'(i)) +: 4];
            end
        end
        cur_c = hit_c && act_cursor_en_q && blink_on_q && (act_cursor_idx_q == idx_c) &&
                (32'(act_cursor_idx_q) < NTILES);
    end

    logic       s1_hit_q;
    logic [9:0] s1_ox_q;
    logic [9:0] s1_oy_q;
    logic [3:0] s1_digit_q;
    logic       s1_cur_q;
    logic       s1_de_q;

    // S2: which segment region (if any) the pixel lies in, bit order {g,f,e,d,c,b,a}
    logic       inner_x;
    logic       upper;
    logic [6:0] mask_c;

    assign inner_x = (s1_ox_q >= T_L) && (s1_ox_q < W_IN);
    assign upper   = (s1_oy_q < H_HALF);

    always_comb begin
        mask_c    = 7'd0;
        mask_c[0] = (s1_oy_q < T_L) && inner_x;
        mask_c[1] = (s1_ox_q >= W_IN) && upper;
        mask_c[2] = (s1_ox_q >= W_IN) && !upper;
        mask_c[3] = (s1_oy_q >= D_LO) && inner_x;
        mask_c[4] = (s1_ox_q < T_L) && !upper;
        mask_c[5] = (s1_ox_q < T_L) && upper;
        mask_c[6] = (s1_oy_q >= G_LO) && (s1_oy_q < G_HI) && inner_x;
        if (!s1_hit_q) begin
            mask_c = 7'd0;
        end
    end

    logic [3:0] s2_digit_q;
    logic [6:0] s2_mask_q;
    logic       s2_cur_q;
    logic       s2_de_q;

    // S3: colour resolve
    logic       lit;
    logic [2:0] r_q;
    logic [2:0] g_q;
    logic [1:0] b_q;

    assign lit = |(s2_mask_q & digit_segs(s2_digit_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit_q   <= 1'b0;
            s1_ox_q    <= 10'd0;
            s1_oy_q    <= 10'd0;
            s1_digit_q <= 4'd0;
            s1_cur_q   <= 1'b0;
            s1_de_q    <= 1'b0;
            s2_digit_q <= 4'd0;
            s2_mask_q  <= 7'd0;
            s2_cur_q   <= 1'b0;
            s2_de_q    <= 1'b0;
            r_q        <= 3'd0;
            g_q        <= 3'd0;
            b_q        <= 2'd0;
        end else begin
            s1_hit_q   <= hit_c;
            s1_ox_q    <= ox_c;
            s1_oy_q    <= oy_c;
            s1_digit_q <= digit_c;
            s1_cur_q   <= cur_c;
            s1_de_q    <= bus.de;

            s2_digit_q <= s1_digit_q;
            s2_mask_q  <= mask_c;
            s2_cur_q   <= s1_cur_q;
            s2_de_q    <= s1_de_q;

            if (!s2_de_q) begin
                {r_q, g_q, b_q} <= 8'h00;
            end else if (s2_cur_q) begin
                {r_q, g_q, b_q} <= lit ? {3'd7, 3'd7, 2'd0} : {3'd0, 3'd0, 2'd2};
            end else if (lit) begin
                {r_q, g_q, b_q} <= {3'd7, 3'd7, 2'd3};
            end else begin
                {r_q, g_q, b_q} <= 8'h00;
            end
        end
    end

    assign bus.vga_r = r_q;
    assign bus.vga_g = g_q;
    assign bus.vga_b = b_q;
endmodule
